// File: rtl/regfile_pkg.sv
// Shared types and constants for the multiport register file and its clear sequencer.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequencer that walks the register array one entry per cycle, writing zeros,
// after reset or on request; owns the busy flag seen by the rest of the block.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic              clr_start,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

  clr_state_t      state;
  logic [ADDR_W:0] cnt;

  // Busy is registered alongside the state so it drops on the edge that clears the last entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we    = (state == CLEAR);
  assign clr_start = (state == IDLE) && clr_req;
  assign clr_addr  = cnt[ADDR_W-1:0];

endmodule

// File: rtl/multiport_regfile.sv
// Multiport register file with optional hardwired zero entry and pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;

  logic              clr_we;
  logic              clr_start;
  logic [ADDR_W-1:0] clr_addr;

  logic [ADDR_W-1:0] rd_addr_a [NUM_RD];
  logic [DATA_W-1:0] rd_val    [NUM_RD];
  logic [ADDR_W-1:0] wa_a      [NUM_WR];
  logic [DATA_W-1:0] wd_a      [NUM_WR];
  logic [NUM_WR-1:0] wr_ok;
  logic              pend_ok;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
    .clk       (clk),
    .reset     (reset),
    .clr_req   (clr_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_start (clr_start),
    .clr_addr  (clr_addr)
  );

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wa_a[j]  = wa[j*ADDR_W +: ADDR_W];
    assign wd_a[j]  = wd[j*DATA_W +: DATA_W];
    // A write commits only when idle and not aimed at the hardwired zero entry.
    assign wr_ok[j] = we[j] && !busy && !((ZERO_REG != 0) && (wa_a[j] == '0));
  end

  assign pend_ok = pend_set && !busy && !((ZERO_REG != 0) && (pend_addr == '0));

  // Later loop iterations override earlier ones, so the highest write port wins.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j]) mem[wa_a[j]] <= wd_a[j];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
    end else if (clr_start || busy) begin
      pend <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j]) pend[wa_a[j]] <= 1'b0;
      end
      if (pend_ok) pend[pend_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_addr_a[i]                = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_data[i*DATA_W +: DATA_W] = rd_val[i];
    assign rd_pend[i]                  = !busy && pend[rd_addr_a[i]];
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_val[i] = '0;
      if (!busy && !((ZERO_REG != 0) && (rd_addr_a[i] == '0))) begin
        rd_val[i] = mem[rd_addr_a[i]];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_ok[j] && (wa_a[j] == rd_addr_a[i])) rd_val[i] = wd_a[j];
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed self-checking bench for multiport_regfile (default parameters, 2R/2W, 32 entries).
module tb_multiport_regfile;

  logic        clk;
  logic        reset;
  logic        clr_req;
  logic        busy;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic        pend_set;
  logic [4:0]  pend_addr;

  int checks = 0;
  int errors = 0;
  int n;

  multiport_regfile dut (
    .clk       (clk),
    .reset     (reset),
    .clr_req   (clr_req),
    .busy      (busy),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_pend   (rd_pend),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .pend_set  (pend_set),
    .pend_addr (pend_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] w_en, input logic [4:0] a0, input logic [31:0] d0,
                               input logic [4:0] a1, input logic [31:0] d1,
                               input logic ps, input logic [4:0] pa);
    we        = w_en;
    wa        = {a1, a0};
    wd        = {d1, d0};
    pend_set  = ps;
    pend_addr = pa;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until busy falls, bounded so a stuck sequencer still reaches the summary.
  task automatic countBusy(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      checkOutput(tag, rd_data, 64'h0);
    end
  endtask

  initial begin
    reset   = 1'b1;
    clr_req = 1'b0;
    rd_addr = '0;
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    tick();
    checkOutput("reset_busy", {63'h0, busy}, 64'h1);
    checkOutput("reset_pend", {62'h0, rd_pend}, 64'h0);
    reset = 1'b0;
    countBusy(n);
    checkOutput("reset_clear_len", 64'(n), 64'd32);
    checkAllZero("after_reset_zero");

    // Single write and its visibility timing.
    rd_addr = {5'd0, 5'd5};
    applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("same_cycle_read", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
`else
    checkOutput("same_cycle_read", {32'h0, rd_data[31:0]}, 64'h0);
`endif
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("next_cycle_read", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);

    // Two ports on the same entry: port 1 wins.
    applyStimulus(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    rd_addr = {5'd7, 5'd5};
    #1;
    checkOutput("dual_write_prio", rd_data, {32'h22, 32'hDEADBEEF});

    // Hardwired zero entry.
    applyStimulus(2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0, 1'b0, 5'd0);
    rd_addr = {5'd0, 5'd0};
    #1;
    checkOutput("zero_same_cycle", rd_data, 64'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0);
    #1;
    checkOutput("zero_after_write", rd_data, 64'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("zero_never_pending", {62'h0, rd_pend}, 64'h0);

    // Pending scoreboard.
    rd_addr = {5'd5, 5'd9};
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9);
    #1;
    checkOutput("pend_not_early", {62'h0, rd_pend}, 64'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("pend_set", {62'h0, rd_pend}, 64'h1);
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd9, 32'h77, 1'b0, 5'd0);
    #1;
    checkOutput("pend_held_during_write", {62'h0, rd_pend}, 64'h1);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("pend_cleared_by_write", {62'h0, rd_pend}, 64'h0);
    applyStimulus(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b1, 5'd9);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("pend_set_wins", {62'h0, rd_pend}, 64'h1);
    checkOutput("pend_set_wins_data", {32'h0, rd_data[31:0]}, 64'h99);

    // Fill the array, then request a clear and try to write during it.
    for (int a = 1; a < 32; a++) begin
      applyStimulus(2'b01, 5'(a), 32'h1000_0000 | 32'(a), 5'd0, 32'h0, 1'b0, 5'd0);
      tick();
    end
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    rd_addr = {5'd3, 5'd31};
    #1;
    checkOutput("fill_read", rd_data, {32'h1000_0003, 32'h1000_001F});
    rd_addr = {5'd3, 5'd9};
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    checkOutput("clr_busy", {63'h0, busy}, 64'h1);
    checkOutput("clr_reads_zero", rd_data, 64'h0);
    checkOutput("clr_pend_zero", {62'h0, rd_pend}, 64'h0);
    n = 0;
    while (busy && n < 200) begin
      if (n == 10)
        applyStimulus(2'b11, 5'd3, 32'hABC, 5'd4, 32'hDEF, 1'b1, 5'd3);
      else
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
      n++;
      tick();
    end
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("clr_len", 64'(n), 64'd32);
    rd_addr = {5'd3, 5'd9};
    #1;
    checkOutput("clr_pend_after", {62'h0, rd_pend}, 64'h0);
    checkAllZero("after_clr_zero");

    // Reset partway through a clear restarts it from entry 0.
    applyStimulus(2'b01, 5'd20, 32'h2020, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    reset = 1'b1;
    #1;
    checkOutput("midclr_reset_busy", {63'h0, busy}, 64'h1);
    tick();
    reset = 1'b0;
    countBusy(n);
    checkOutput("midclr_restart_len", 64'(n), 64'd32);

    applyStimulus(2'b01, 5'd12, 32'h55, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    rd_addr = {5'd20, 5'd12};
    #1;
    checkOutput("post_restart_rw", rd_data, {32'h0, 32'h55});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
